// File: rtl/complex_delay_line.sv
// complex_delay_line: multi-lane delay line for packed complex elements
// (real part in the upper half of each element, imaginary part in the lower half).
// The tap depth is selected at runtime through delay_sel.
// Each stage carries a valid bit that is shared by all lanes.
// Build option: define CDL_CONJ_EN to add the conj_sel input.
// When conj_sel is high, the imaginary half of every output lane is negated.
//
// Valid semantics: din_valid qualifies din for all lanes.
// On an enabled edge the (din, din_valid) pair enters stage 0.
// Data moves regardless of its valid bit, and nothing ever back-pressures the input.
// dout_valid is the valid bit of the selected tap.
module complex_delay_line #(
  parameter int ELEMENT_SIZE = 16,
  parameter int CHANNELS     = 4,
  parameter int MAX_STAGES   = 8,
  parameter int SEL_WIDTH    = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic                             flush,
  input  logic [SEL_WIDTH-1:0]             delay_sel,
`ifdef CDL_CONJ_EN
  input  logic                             conj_sel,
`endif
  input  logic [CHANNELS*ELEMENT_SIZE-1:0] din,
  input  logic                             din_valid,
  output logic [CHANNELS*ELEMENT_SIZE-1:0] dout,
  output logic                             dout_valid,
  output logic [SEL_WIDTH-1:0]             fill_count,
  output logic                             sel_err
);

  localparam int DATA_W = CHANNELS * ELEMENT_SIZE;
  localparam int HALF   = ELEMENT_SIZE / 2;
  localparam logic [SEL_WIDTH-1:0] MAX_SEL = SEL_WIDTH'(MAX_STAGES);

  logic [DATA_W-1:0]     stage_data [MAX_STAGES];
  logic [MAX_STAGES-1:0] stage_valid;
  logic                  sel_err_q;
  logic                  sel_bad;
  logic [SEL_WIDTH-1:0]  tap;
  logic [DATA_W-1:0]     tap_data;
  logic                  tap_valid;
  logic [SEL_WIDTH-1:0]  fill;

  // Clamp the requested delay to 1..MAX_STAGES and turn it into a stage index.
  always_comb begin
    sel_bad = (delay_sel == '0) || (delay_sel > MAX_SEL);
    if (delay_sel == '0) begin
      tap = '0;
    end else if (delay_sel > MAX_SEL) begin
      tap = MAX_SEL - SEL_WIDTH'(1);
    end else begin
      tap = delay_sel - SEL_WIDTH'(1);
    end
  end

  // Shift register. Flush has priority over enable, and data is never gated by valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_STAGES; i++) stage_data[i] <= '0;
      stage_valid <= '0;
    end else if (flush) begin
      for (int i = 0; i < MAX_STAGES; i++) stage_data[i] <= '0;
      stage_valid <= '0;
    end else if (enable) begin
      stage_data[0] <= din;
      for (int i = 1; i < MAX_STAGES; i++) stage_data[i] <= stage_data[i-1];
      stage_valid <= {stage_valid[MAX_STAGES-2:0], din_valid};
    end
  end

  // Sticky range error. It is only sampled on enabled cycles, and flush clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_err_q <= 1'b0;
    end else if (flush) begin
      sel_err_q <= 1'b0;
    end else if (enable && sel_bad) begin
      sel_err_q <= 1'b1;
    end
  end

  // Tap multiplexer, plus a count of the valid bits in stages 0..tap.
  always_comb begin
    tap_data  = '0;
    tap_valid = 1'b0;
    fill      = '0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (tap == SEL_WIDTH'(i)) begin
        tap_data  = stage_data[i];
        tap_valid = stage_valid[i];
      end
      if ((SEL_WIDTH'(i) <= tap) && stage_valid[i]) begin
        fill = fill + SEL_WIDTH'(1);
      end
    end
  end

`ifdef CDL_CONJ_EN
  // Optional conjugate: the imaginary half is negated modulo 2**HALF; stored data is untouched.
  always_comb begin
    dout = tap_data;
    if (conj_sel) begin
      for (int k = 0; k < CHANNELS; k++) begin
        dout[k*ELEMENT_SIZE +: HALF] = ~tap_data[k*ELEMENT_SIZE +: HALF] + HALF'(1);
      end
    end
  end
`else
  assign dout = tap_data;
`endif

  assign dout_valid = tap_valid;
  assign fill_count = fill;
  assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_complex_delay_line.sv
// tb_complex_delay_line: bench for complex_delay_line.
// The reference model keeps the history of accepted (valid, data) pairs, newest first.
// For a clamped delay d, the expected output is the pair accepted d enabled edges ago.
module tb_complex_delay_line;

  localparam int E  = 16;
  localparam int C  = 4;
  localparam int M  = 8;
  localparam int S  = 4;
  localparam int DW = C * E;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic [S-1:0]  delay_sel = '0;
`ifdef CDL_CONJ_EN
  logic          conj_sel = 1'b0;
`endif
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [S-1:0]  fill_count;
  logic          sel_err;

  int checks = 0;
  int errors = 0;

  // Model state: history of accepted items (index 0 = most recent), plus the sticky flag.
  logic [DW:0]   hist[$];
  logic          m_err;
  logic [DW-1:0] exp_dout;
  logic          exp_dv;
  logic [S-1:0]  exp_fill;

  complex_delay_line #(
    .ELEMENT_SIZE(E), .CHANNELS(C), .MAX_STAGES(M), .SEL_WIDTH(S)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .delay_sel(delay_sel),
`ifdef CDL_CONJ_EN
    .conj_sel(conj_sel),
`endif
    .din(din), .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid),
    .fill_count(fill_count), .sel_err(sel_err)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < M; i++) hist.push_back('0);
    m_err = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic fl, input logic [S-1:0] sel,
                            input logic [DW-1:0] d, input logic dv);
    if (fl) begin
      model_clear();
    end else if (en) begin
      hist.push_front({dv, d});
      void'(hist.pop_back());
      if (sel < 1 || sel > M) m_err = 1'b1;
    end
  endtask

  task automatic model_expect(input logic [S-1:0] sel);
    int d;
    int cnt;
    d = int'(sel);
    if (d < 1) d = 1;
    if (d > M) d = M;
    exp_dout = hist[d-1][DW-1:0];
    exp_dv   = hist[d-1][DW];
    cnt = 0;
    for (int i = 0; i < d; i++) if (hist[i][DW]) cnt++;
    exp_fill = S'(cnt);
  endtask

  // Driver: apply inputs, take one clock edge, update the model, settle 1 time unit.
  task automatic step(input logic en, input logic fl, input logic [S-1:0] sel,
                      input logic [DW-1:0] d, input logic dv);
    enable = en; flush = fl; delay_sel = sel; din = d; din_valid = dv;
    @(posedge clk);
    model_edge(en, fl, sel, d, dv);
    #1;
    model_expect(sel);
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    model_clear();
    #12;
    checks++;
    if ({dout, dout_valid, fill_count, sel_err} !== {{DW{1'b0}}, 1'b0, {S{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_initial dout=%h dv=%b fill=%0d err=%b required all zero",
               dout, dout_valid, fill_count, sel_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    // Fill the line, and set sel_err, so the mid-stream reset has something to discard.
    step(1'b1, 1'b0, S'(0), rand_data(), 1'b1);
    for (int i = 0; i < M; i++) step(1'b1, 1'b0, S'(M), rand_data(), 1'b1);
    checks++;
    if ({dout_valid, fill_count, sel_err} !== {1'b1, S'(M), 1'b1}) begin
      errors++;
      $display("FAIL reset_prefill dv=%b fill=%0d err=%b required 1 %0d 1",
               dout_valid, fill_count, sel_err, M);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({dout, dout_valid, fill_count, sel_err} !== {{DW{1'b0}}, 1'b0, {S{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_async dout=%h dv=%b fill=%0d err=%b required all zero",
               dout, dout_valid, fill_count, sel_err);
    end
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fixed_delay();
    int fill_tab[8] = '{1, 2, 3, 3, 3, 2, 1, 0};
    int dv_tab[8]   = '{0, 0, 1, 1, 1, 1, 1, 0};
    logic [DW-1:0] d;
    step(1'b0, 1'b1, S'(3), '0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      d = '0;
      for (int k = 0; k < C; k++) d[k*E +: E] = E'(16'h0101 * k + c);
      step(1'b1, 1'b0, S'(3), d, (c < 5));
      checks++;
      if ({dout, dout_valid, fill_count, sel_err} !== {exp_dout, exp_dv, exp_fill, m_err}) begin
        errors++;
        $display("FAIL fixed_model c=%0d dout=%h dv=%b fill=%0d err=%b required %h %b %0d %b",
                 c, dout, dout_valid, fill_count, sel_err, exp_dout, exp_dv, exp_fill, m_err);
      end
      checks++;
      if (fill_count !== S'(fill_tab[c]) || dout_valid !== dv_tab[c][0]) begin
        errors++;
        $display("FAIL fixed_ramp c=%0d fill=%0d dv=%b required %0d %0d",
                 c, fill_count, dout_valid, fill_tab[c], dv_tab[c]);
      end
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] a;
    int found;
    a = rand_data();
    found = 0;
    step(1'b0, 1'b1, S'(4), '0, 1'b0);
    // Clock 1 accepts a. Clock 2 is enabled. Clocks 3-4 are stalled. Enabled clocks follow.
    for (int clk_n = 1; clk_n <= 10; clk_n++) begin
      if (clk_n == 1)      step(1'b1, 1'b0, S'(4), a, 1'b1);
      else if (clk_n == 2) step(1'b1, 1'b0, S'(4), ~a, 1'b1);
      else if (clk_n <= 4) step(1'b0, 1'b0, S'(4), rand_data(), 1'b1);
      else                 step(1'b1, 1'b0, S'(4), rand_data(), 1'b0);
      checks++;
      if ({dout, dout_valid, fill_count, sel_err} !== {exp_dout, exp_dv, exp_fill, m_err}) begin
        errors++;
        $display("FAIL stall_model clk=%0d dout=%h dv=%b fill=%0d required %h %b %0d",
                 clk_n, dout, dout_valid, fill_count, exp_dout, exp_dv, exp_fill);
      end
      if (found == 0 && dout_valid === 1'b1 && dout === a) found = clk_n;
    end
    checks++;
    if (found != 6) begin
      errors++;
      $display("FAIL stall_latency clocks=%0d required 6", found);
    end
  endtask

  task automatic test_clamp_err();
    logic [DW-1:0] x;
    x = rand_data();
    step(1'b0, 1'b1, S'(3), '0, 1'b0);
    step(1'b1, 1'b0, S'(0), x, 1'b1);
    checks++;
    if ({dout, dout_valid, sel_err} !== {x, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL clamp_zero dout=%h dv=%b err=%b required %h 1 1", dout, dout_valid, sel_err, x);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, S'(12), rand_data(), 1'($urandom_range(0, 1)));
      checks++;
      if ({dout, dout_valid, fill_count, sel_err} !== {exp_dout, exp_dv, exp_fill, 1'b1}) begin
        errors++;
        $display("FAIL clamp_high i=%0d dout=%h dv=%b fill=%0d err=%b required %h %b %0d 1",
                 i, dout, dout_valid, fill_count, sel_err, exp_dout, exp_dv, exp_fill);
      end
    end
    step(1'b0, 1'b1, S'(12), '0, 1'b0);
    checks++;
    if (sel_err !== 1'b0) begin
      errors++;
      $display("FAIL err_flush_clear err=%b required 0", sel_err);
    end
    step(1'b0, 1'b0, S'(0), rand_data(), 1'b1);
    step(1'b0, 1'b0, S'(15), rand_data(), 1'b1);
    checks++;
    if (sel_err !== 1'b0 || fill_count !== '0) begin
      errors++;
      $display("FAIL err_disabled err=%b fill=%0d required 0 0", sel_err, fill_count);
    end
  endtask

  task automatic test_flush_priority();
    logic [DW-1:0] y;
    y = rand_data();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, S'(9), rand_data(), 1'b1);
    step(1'b1, 1'b1, S'(3), {C{16'hABCD}}, 1'b1);
    checks++;
    if ({dout, dout_valid, fill_count, sel_err} !== {{DW{1'b0}}, 1'b0, {S{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL flush_priority dout=%h dv=%b fill=%0d err=%b required all zero",
               dout, dout_valid, fill_count, sel_err);
    end
    step(1'b1, 1'b0, S'(3), y, 1'b1);
    step(1'b1, 1'b0, S'(3), rand_data(), 1'b0);
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_early dv=%b required 0", dout_valid);
    end
    step(1'b1, 1'b0, S'(3), rand_data(), 1'b0);
    checks++;
    if ({dout, dout_valid, fill_count} !== {y, 1'b1, S'(1)}) begin
      errors++;
      $display("FAIL flush_emerge dout=%h dv=%b fill=%0d required %h 1 1", dout, dout_valid, fill_count, y);
    end
  endtask

  task automatic test_random();
    logic en;
    logic fl;
    logic [S-1:0] sel;
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 24) == 0);
      sel = S'($urandom_range(0, 15));
      step(en, fl, sel, rand_data(), 1'($urandom_range(0, 1)));
      checks++;
      if ({dout, dout_valid, fill_count, sel_err} !== {exp_dout, exp_dv, exp_fill, m_err}) begin
        errors++;
        $display("FAIL random i=%0d sel=%0d dout=%h dv=%b fill=%0d err=%b required %h %b %0d %b",
                 i, sel, dout, dout_valid, fill_count, sel_err, exp_dout, exp_dv, exp_fill, m_err);
      end
    end
  endtask

`ifdef CDL_CONJ_EN
  task automatic test_conj();
    logic [E-1:0] in_tab[3]  = '{16'h1234, 16'h05FB, 16'h0780};
    logic [E-1:0] out_tab[3] = '{16'h12CC, 16'h0505, 16'h0780};
    step(1'b0, 1'b1, S'(1), '0, 1'b0);
    conj_sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, S'(1), {C{in_tab[i]}}, 1'b1);
      checks++;
      if (dout !== {C{out_tab[i]}}) begin
        errors++;
        $display("FAIL conj i=%0d dout=%h required %h", i, dout, {C{out_tab[i]}});
      end
    end
    step(1'b1, 1'b0, S'(1), {C{in_tab[0]}}, 1'b1);
    conj_sel = 1'b0;
    #1;
    checks++;
    if (dout !== {C{16'h1234}}) begin
      errors++;
      $display("FAIL conj_off dout=%h required %h", dout, {C{16'h1234}});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed_delay();
    test_stall();
    test_clamp_err();
    test_flush_priority();
    test_random();
`ifdef CDL_CONJ_EN
    test_conj();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/complex_delay_line.md
Name: complex_delay_line

Overview:
- Multi-channel, runtime-tapped delay line for packed complex elements. Real part is in the upper half of each element; imaginary part is in the lower half.
- Aligns operand streams feeding the complex multiply/accumulate array when the required skew changes per matrix dimension.
- Generalises the fixed-depth shift register:
  - per-lane packing;
  - per-stage valid tracking;
  - selectable tap depth;
  - synchronous flush;
  - window fill count;
  - sticky range-error flag.

Parameters:
- ELEMENT_SIZE, 16, bits per complex element (even; ELEMENT_SIZE/2 per component).
- CHANNELS, 4, independent lanes packed into din/dout; lane k occupies bits [k*ELEMENT_SIZE +: ELEMENT_SIZE].
- MAX_STAGES, 8, physical depth of each lane (>=2).
- SEL_WIDTH, 4, width of delay_sel; must satisfy 2**SEL_WIDTH > MAX_STAGES.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  shift strobe; stages advance only when high.
- flush  input  1  synchronous clear of all stages, valids and error flag.
- delay_sel  input  SEL_WIDTH  requested delay in enabled cycles, legal 1..MAX_STAGES.
- din  input  CHANNELS*ELEMENT_SIZE  packed input elements.
- din_valid  input  1  qualifies din, shared by all lanes.
- dout  output  CHANNELS*ELEMENT_SIZE  packed elements at the selected tap.
- dout_valid  output  1  valid bit at the selected tap.
- fill_count  output  SEL_WIDTH  number of valid entries in stages 0..tap.
- sel_err  output  1  sticky: delay_sel was out of range on an enabled cycle.

Behaviour:
- Reset (reset_n low, asynchronous): all stage data 0, all stage valids 0, sel_err 0. Outputs are therefore dout=0, dout_valid=0, fill_count=0, sel_err=0. Reset mid-stream discards all contents immediately.
- Storage: stage[0..MAX_STAGES-1] per lane, plus one shared valid bit per stage.
- Shift on rising clk, priority flush > enable:
  - flush=1: all data 0, all valids 0, sel_err 0, whatever the value of enable.
  - enable=1: stage[0] <= din, valid[0] <= din_valid; stage[i] <= stage[i-1] and valid[i] <= valid[i-1] for i>0.
  - enable=0: hold everything.
- Invalid entries still shift their data; data is never gated by valid.
- Tap index: tap = clamp(delay_sel,1,MAX_STAGES) - 1. delay_sel=0 selects stage 0; delay_sel>MAX_STAGES selects stage MAX_STAGES-1.
- Output path: dout = stage[tap], dout_valid = valid[tap], combinational from registers with no added register.
  - Latency: an element accepted on enabled edge N appears at dout after delay_sel enabled edges, counting edge N.
- delay_sel change takes effect in the same cycle. No retiming is done: entries already inside the line are re-tapped, and elements may be skipped or repeated. Upstream changes delay_sel only after a flush.
- fill_count = popcount(valid[0..tap]), combinational; its maximum is MAX_STAGES.
- sel_err: set on a rising edge where enable=1, flush=0 and (delay_sel==0 or delay_sel>MAX_STAGES).
  - It stays set until flush or reset; flush wins over a simultaneous set.
  - An out-of-range delay_sel while enable=0 does not set it.
- Simultaneous flush and enable: flush wins, and din is dropped.
- Lanes share control; no per-lane enable.

Optional Feature:
- Macro CDL_CONJ_EN.
- Defined:
  - Extra input conj_sel (1 bit) is added after delay_sel.
  - When conj_sel=1, every dout lane outputs {real, -imag}. The imaginary half is two's-complement negated modulo 2**(ELEMENT_SIZE/2), so the most-negative value maps to itself.
  - Applied combinationally at the output only; stored contents are unchanged.
- Undefined: no conj_sel port; dout is the stored stage unmodified.

Test Plan:
- Reset: apply reset_n=0 mid-stream with the line full -> dout=0, dout_valid=0, fill_count=0, sel_err=0 in the same cycle, without waiting for a clock edge.
- Fixed delay: CHANNELS=4, delay_sel=3, enable=1, din lanes = 0x0101*k + cycle with din_valid=1 for 5 cycles -> each element appears on dout exactly 3 edges after acceptance; dout_valid high for 5 consecutive cycles; fill_count ramps 1,2,3 then holds at 3 and drains 2,1,0 after din_valid drops.
- Stall: delay_sel=4, enable low for 2 cycles mid-stream -> dout and fill_count hold; data order is preserved and latency becomes 4 enabled edges (6 clocks).
- Clamp and error:
  - delay_sel=0 with enable=1 -> tap stage 0, sel_err=1 after the edge.
  - delay_sel=12 with MAX_STAGES=8 -> tap stage 7.
  - sel_err then stays 1 until a flush edge, after which it reads 0.
- Flush priority: flush=1 and enable=1 with din=0xABCD, din_valid=1 -> after the edge all valids 0, dout=0, fill_count=0, sel_err=0; the next enabled element takes a full delay_sel cycles to emerge.
- CDL_CONJ_EN build: stage holds 0x1234, then 0x05FB, then 0x0780; conj_sel=1 -> dout shows 0x12CC, then 0x0505, then 0x0780. With conj_sel=0 -> 0x1234 unchanged.
